// File: rtl/branch_predict_resolver_pkg.sv
// Shared branch codes, FSM states and helpers for the branch predictor/resolver.
// Imported by every branch_predict_resolver file.
package branch_predict_resolver_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_GE   = 3'd3;
    localparam logic [2:0] BR_GT   = 3'd4;
    localparam logic [2:0] BR_LE   = 3'd5;
    localparam logic [2:0] BR_LT   = 3'd6;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Codes 0 and 7 both mean "not a branch".
    function automatic logic is_branch_code(input logic [2:0] code);
        return (code != BR_NONE) && (code != 3'd7);
    endfunction

endpackage

// File: rtl/branch_predict_resolver_if.sv
// IF lookup, EX resolve and status bundle of the branch predictor/resolver.
// master drives fetch/EX inputs, slave is the branch unit.
interface branch_predict_resolver_if #(
    parameter int PC_W   = 32,
    parameter int STAT_W = 16
);
    logic [PC_W-1:0]   if_pc;
    logic              if_pred_taken;
    logic              ex_valid;
    logic [2:0]        ex_branch;
    logic              ex_zero;
    logic              ex_sign;
    logic [PC_W-1:0]   ex_pc;
    logic [PC_W-1:0]   ex_target;
    logic              ex_pred_taken;
    logic              branch_taken;
    logic              mispredict;
    logic [PC_W-1:0]   redirect_pc;
    logic              ready;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output if_pc, ex_valid, ex_branch, ex_zero, ex_sign,
        output ex_pc, ex_target, ex_pred_taken,
        input  if_pred_taken, branch_taken, mispredict,
        input  redirect_pc, ready, stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, ex_valid, ex_branch, ex_zero, ex_sign,
        input  ex_pc, ex_target, ex_pred_taken,
        output if_pred_taken, branch_taken, mispredict,
        output redirect_pc, ready, stat_branches, stat_mispredicts
    );

endinterface

// File: rtl/branch_predict_resolver_cond_decode.sv
// Combinational branch condition decode from ALU zero/sign flags.
module branch_predict_resolver_cond_decode
    import branch_predict_resolver_pkg::*;
(
    input  logic [2:0] branch,
    input  logic       zero,
    input  logic       sign,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (branch)
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            BR_GE:   taken = ~sign | zero;
            BR_GT:   taken = ~sign & ~zero;
            BR_LE:   taken = sign | zero;
            BR_LT:   taken = sign;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_resolver.sv
// Branch unit: BHT of 2-bit counters for IF prediction, EX resolution,
// registered mispredict/redirect and saturating statistics.
module branch_predict_resolver
    import branch_predict_resolver_pkg::*;
#(
    parameter int         IDX_BITS = 6,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         STAT_W   = 16,
    parameter int         PC_W     = 32
) (
    input logic                    clk,
    input logic                    rst,
    branch_predict_resolver_if.slave bus
);

    localparam int DEPTH = 1 << IDX_BITS;

    typedef logic [IDX_BITS-1:0] idx_t;

    state_t     state;
    idx_t       idx;
    logic [1:0] bht [DEPTH];

    logic cond_taken;
    logic run;
    logic is_br;
    logic mp_cond;
    idx_t lk_idx;
    idx_t up_idx;

    branch_predict_resolver_cond_decode u_dec (
        .branch (bus.ex_branch),
        .zero   (bus.ex_zero),
        .sign   (bus.ex_sign),
        .taken  (cond_taken)
    );

    assign run    = (state == ST_RUN);
    assign is_br  = bus.ex_valid & is_branch_code(bus.ex_branch);
    assign lk_idx = bus.if_pc[IDX_BITS+1:2];
    assign up_idx = bus.ex_pc[IDX_BITS+1:2];

    assign bus.branch_taken  = bus.ex_valid & cond_taken;
    assign bus.if_pred_taken = bus.ready & bht[lk_idx][1];
    assign mp_cond = run & is_br & (bus.branch_taken != bus.ex_pred_taken);

    // Init sweep: one table entry per cycle, then RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            idx       <= '0;
            bus.ready <= 1'b0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    idx <= idx + idx_t'(1);
                    if (&idx) begin
                        state     <= ST_RUN;
                        bus.ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                bht[idx] <= CTR_INIT;
            end else if (is_br) begin
                if (bus.branch_taken) begin
                    if (bht[up_idx] != 2'b11)
                        bht[up_idx] <= bht[up_idx] + 2'b01;
                end else begin
                    if (bht[up_idx] != 2'b00)
                        bht[up_idx] <= bht[up_idx] - 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mispredict       <= 1'b0;
            bus.redirect_pc      <= '0;
            bus.stat_branches    <= '0;
            bus.stat_mispredicts <= '0;
        end else begin
            bus.mispredict <= mp_cond;
            if (mp_cond)
                bus.redirect_pc <= bus.branch_taken ? bus.ex_target
                                                    : bus.ex_pc + PC_W'(4);
            if (run & is_br & ~&bus.stat_branches)
                bus.stat_branches <= bus.stat_branches + STAT_W'(1);
            if (mp_cond & ~&bus.stat_mispredicts)
                bus.stat_mispredicts <= bus.stat_mispredicts + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_resolver.sv
// Self-checking bench for branch_predict_resolver against a counter-table model.
// IDX_BITS=4, STAT_W=4 so init sweep and stat saturation are short.
module tb_branch_predict_resolver;

    localparam int IDX_BITS = 4;
    localparam int STAT_W   = 4;
    localparam int PC_W     = 32;
    localparam int DEPTH    = 16;
    localparam int SMAX     = 15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_predict_resolver_if #(.PC_W(PC_W), .STAT_W(STAT_W)) bus ();

    branch_predict_resolver #(
        .IDX_BITS (IDX_BITS),
        .CTR_INIT (2'b01),
        .STAT_W   (STAT_W),
        .PC_W     (PC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int passed = 0;
    int failed = 0;

    int          ctr [DEPTH];
    int          init_left;
    int          n_br;
    int          n_mp;
    bit          exp_mp;
    logic [31:0] exp_rd;

    function automatic bit ref_taken(input int code, input bit z, input bit s);
        case (code)
            1: return z;
            2: return !z;
            3: return !s || z;
            4: return !s && !z;
            5: return s || z;
            6: return s;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int slot(input logic [31:0] pc);
        return int'(pc[IDX_BITS+1:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        init_left = DEPTH;
        n_br = 0;
        n_mp = 0;
        exp_mp = 1'b0;
        for (int i = 0; i < DEPTH; i++) ctr[i] = 1;
    endtask

    task automatic drive(input bit v, input int code, input bit z, input bit s,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input bit pred, input logic [31:0] ipc);
        bus.ex_valid      = v;
        bus.ex_branch     = code[2:0];
        bus.ex_zero       = z;
        bus.ex_sign       = s;
        bus.ex_pc         = pc;
        bus.ex_target     = tgt;
        bus.ex_pred_taken = pred;
        bus.if_pc         = ipc;
    endtask

    task automatic drive_rand();
        drive(1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
              1'($urandom), $urandom, $urandom, 1'($urandom), $urandom);
    endtask

    // One clock: combinational checks, edge, model step, registered checks.
    task automatic tick(input string tag);
        bit tk;
        bit br;
        int e;
        #1;
        tk = bus.ex_valid && ref_taken(int'(bus.ex_branch), bus.ex_zero, bus.ex_sign);
        check({tag, ".taken"}, bus.branch_taken, tk);
        check({tag, ".pred"}, bus.if_pred_taken,
              (init_left == 0) && (ctr[slot(bus.if_pc)] >= 2));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (init_left > 0) begin
            init_left--;
            exp_mp = 1'b0;
        end else begin
            br = bus.ex_valid && bus.ex_branch >= 3'd1 && bus.ex_branch <= 3'd6;
            exp_mp = br && (tk != bus.ex_pred_taken);
            if (br) begin
                e = slot(bus.ex_pc);
                ctr[e] = tk ? ((ctr[e] == 3) ? 3 : ctr[e] + 1)
                            : ((ctr[e] == 0) ? 0 : ctr[e] - 1);
                n_br = (n_br == SMAX) ? SMAX : n_br + 1;
            end
            if (exp_mp) begin
                n_mp = (n_mp == SMAX) ? SMAX : n_mp + 1;
                exp_rd = tk ? bus.ex_target : bus.ex_pc + 32'd4;
            end
        end
        #1;
        check({tag, ".mispredict"}, bus.mispredict, exp_mp);
        check({tag, ".ready"}, bus.ready, init_left == 0);
        check({tag, ".stat_br"}, bus.stat_branches, n_br);
        check({tag, ".stat_mp"}, bus.stat_mispredicts, n_mp);
        if (exp_mp) check({tag, ".redirect"}, bus.redirect_pc, exp_rd);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick(tag);
        rst = 1'b0;
        check({tag, ".redirect0"}, bus.redirect_pc, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.mispredict", bus.mispredict, 1'b0);
        check("rst.redirect", bus.redirect_pc, 32'h0);
        check("rst.ready", bus.ready, 1'b0);
        check("rst.stat_br", bus.stat_branches, 4'd0);
        check("rst.stat_mp", bus.stat_mispredicts, 4'd0);

        // Sweep with EX traffic that must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand();
            tick("init");
        end
        check("init.ready_final", bus.ready, 1'b1);

        for (int c = 0; c < 8; c++) begin
            for (int zs = 0; zs < 4; zs++) begin
                drive(1, c, zs[0], zs[1], $urandom, $urandom, 1'($urandom), $urandom);
                tick("dec");
                drive(0, c, zs[0], zs[1], $urandom, $urandom, 1'($urandom), $urandom);
                tick("dec_inv");
            end
        end

        // Reset in sweep cycle 5 restarts the full sweep.
        do_reset("rstA");
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            tick("rstA.part");
        end
        do_reset("rstA2");
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 32'h40);
            tick("rstA.sweep");
        end

        drive(1, 1, 1, 0, 32'h40, 32'h80, 0, 32'h40);
        tick("train.t1");
        drive(1, 1, 1, 0, 32'h40, 32'h80, 1, 32'h40);
        tick("train.t2");
        drive(0, 0, 0, 0, 0, 0, 0, 32'h40);
        tick("train.hi");
        check("train.pred_taken", bus.if_pred_taken, 1'b1);
        drive(1, 1, 0, 0, 32'h40, 32'h80, 1, 32'h40);
        tick("train.n1");
        drive(1, 1, 0, 0, 32'h40, 32'h80, 1, 32'h40);
        tick("train.n2");
        drive(0, 0, 0, 0, 0, 0, 0, 32'h40);
        tick("train.lo");
        check("train.pred_not", bus.if_pred_taken, 1'b0);

        drive(1, 1, 1, 0, 32'h100, 32'h200, 0, 0);
        tick("mpA");
        check("mpA.redirect_c", bus.redirect_pc, 32'h200);
        drive(1, 1, 0, 0, 32'h100, 32'h200, 1, 0);
        tick("mpB");
        check("mpB.redirect_c", bus.redirect_pc, 32'h104);
        drive(1, 1, 1, 0, 32'h100, 32'h200, 1, 0);
        tick("mpC");
        drive(1, 7, 1, 0, 32'h100, 32'h200, 1, 0);
        tick("mp.nonbr7");
        drive(1, 0, 1, 0, 32'h100, 32'h200, 1, 0);
        tick("mp.nonbr0");
        drive(1, 2, 1, 0, 32'hFFFF_FFFC, 32'h10, 1, 0);
        tick("mp.wrap");
        check("wrap.redirect_c", bus.redirect_pc, 32'h0);

        // Reset on the edge that would register a mispredict.
        drive(1, 1, 1, 0, 32'h100, 32'h200, 0, 0);
        do_reset("rstB");
        check("rstB.stat_mp0", bus.stat_mispredicts, 4'd0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick("rstB.sweep");
        end

        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 1, 0, $urandom, $urandom, 0, $urandom);
            tick("sat");
        end
        check("sat.stat_br15", bus.stat_branches, 4'd15);
        check("sat.stat_mp15", bus.stat_mispredicts, 4'd15);

        do_reset("rnd.rst");
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick("rnd.sweep");
        end
        for (int i = 0; i < 300; i++) begin
            logic [31:0] pc;
            bit pred;
            pc = 32'h1000 + 32'($urandom_range(0, 5)) * 4;
            pred = ($urandom_range(0, 3) != 0) ? (ctr[slot(pc)] >= 2) : 1'($urandom);
            drive(1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), pc, $urandom, pred,
                  32'h1000 + 32'($urandom_range(0, 5)) * 4);
            tick("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
